// File: rtl/spi_flash_pkg.sv
// ----------------------------------------------------------------------------
// spi_flash_pkg : opcodes, command codes, frame lengths and FSM states shared
//                 by the SPI flash writer and the quad instruction reader.
// Revision      : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package spi_flash_pkg;

  localparam logic [7:0] c_OP_WREN = 8'h06;
  localparam logic [7:0] c_OP_PP   = 8'h02;
  localparam logic [7:0] c_OP_SE   = 8'h20;
  localparam logic [7:0] c_OP_CE   = 8'hC7;
  localparam logic [7:0] c_OP_RDSR = 8'h05;

  localparam logic [7:0] c_STATUS_WIP = 8'h01;

  localparam logic [1:0] c_CMD_PROGRAM = 2'd0;
  localparam logic [1:0] c_CMD_SECTOR  = 2'd1;
  localparam logic [1:0] c_CMD_CHIP    = 2'd2;
  localparam logic [1:0] c_CMD_ILLEGAL = 2'd3;

  localparam int unsigned c_FRAME_W = 64;
  localparam int unsigned c_LEN_W   = 7;

  localparam logic [c_LEN_W-1:0] c_LEN_OPCODE  = 7'd8;
  localparam logic [c_LEN_W-1:0] c_LEN_SECTOR  = 7'd32;
  localparam logic [c_LEN_W-1:0] c_LEN_PROGRAM = 7'd64;
  localparam logic [c_LEN_W-1:0] c_LEN_POLL    = 7'd16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WREN   = 3'd1,
    S_GAP    = 3'd2,
    S_OPER   = 3'd3,
    S_POLL   = 3'd4,
    S_FINISH = 3'd5,
    S_REJECT = 3'd6
  } state_t;

  // Left-justified frame for the program/erase command; address is a word address.
  function automatic logic [c_FRAME_W-1:0] oper_frame(input logic [1:0]  cmd,
                                                      input logic [23:0] address,
                                                      input logic [31:0] wdata);
    logic [23:0] byte_addr;
    byte_addr = address << 2;
    case (cmd)
      c_CMD_PROGRAM: oper_frame = {c_OP_PP, byte_addr, wdata};
      c_CMD_SECTOR:  oper_frame = {c_OP_SE, byte_addr, 32'h0};
      default:       oper_frame = {c_OP_CE, 56'h0};
    endcase
  endfunction

  function automatic logic [c_LEN_W-1:0] oper_len(input logic [1:0] cmd);
    case (cmd)
      c_CMD_PROGRAM: oper_len = c_LEN_PROGRAM;
      c_CMD_SECTOR:  oper_len = c_LEN_SECTOR;
      default:       oper_len = c_LEN_OPCODE;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_flash_writer_shift.sv
// ----------------------------------------------------------------------------
// spi_shift_engine : mode-0 single-bit frame shifter (MSB first), 2 clk per bit,
//                    drives cs_n/sclk/mosi and captures the last 8 miso bits.
// Revision         : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module spi_shift_engine
  import spi_flash_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [c_LEN_W-1:0]   length,
  input  logic [c_FRAME_W-1:0] tx_data,
  input  logic                 miso,
  output logic                 cs_n,
  output logic                 sclk,
  output logic                 mosi,
  output logic                 frame_done,
  output logic [7:0]           rx_byte
);

  logic                 r_active;
  logic                 r_phase_b;
  logic [c_LEN_W-1:0]   r_bits_left;
  logic [c_FRAME_W-1:0] r_shift;
  logic [6:0]           r_rx;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_active    <= 1'b0;
      r_phase_b   <= 1'b0;
      r_bits_left <= '0;
      r_shift     <= '0;
      r_rx        <= '0;
    end else if (load) begin
      r_active    <= 1'b1;
      r_phase_b   <= 1'b0;
      r_bits_left <= length;
      r_shift     <= tx_data;
    end else if (r_active) begin
      if (!r_phase_b) begin
        r_phase_b <= 1'b1;
      end else begin
        // End of phase B: sample miso, advance to the next bit cell
        r_phase_b   <= 1'b0;
        r_rx        <= {r_rx[5:0], miso};
        r_shift     <= {r_shift[c_FRAME_W-2:0], 1'b0};
        r_bits_left <= r_bits_left - 7'd1;
        if (r_bits_left == 7'd1) begin
          r_active <= 1'b0;
        end
      end
    end
  end

  assign cs_n       = ~r_active;
  assign sclk       = r_active & r_phase_b;
  assign mosi       = r_active & r_shift[c_FRAME_W-1];
  // Asserted during the last phase B so the sequencer can act on the closing edge
  assign frame_done = r_active & r_phase_b & (r_bits_left == 7'd1);
  assign rx_byte    = {r_rx, miso};

endmodule

`default_nettype wire

// File: rtl/spi_flash_writer.sv
// ----------------------------------------------------------------------------
// spi_flash_writer : SPI NOR program/erase master: WREN, command frame, then
//                    status polling until WIP clears or the poll limit expires.
// Revision         : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module spi_flash_writer
  import spi_flash_pkg::*;
#(
  parameter int unsigned CS_GAP     = 4,
  parameter logic [23:0] POLL_LIMIT = 24'd4_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  cmd,
  input  logic [23:0] address,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        bus_active,
  output logic        cs_n,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic        wp_n,
  output logic        hold_n
);

  localparam int unsigned c_GAP_W = (CS_GAP > 2) ? $clog2(CS_GAP) : 1;

  state_t               r_state;
  state_t               w_next_state;
  logic [1:0]           r_cmd;
  logic [23:0]          r_address;
  logic [31:0]          r_wdata;
  logic                 r_error;
  logic                 r_oper_pending;
  logic [23:0]          r_poll_cnt;
  logic [c_GAP_W-1:0]   r_gap_cnt;

  logic                 w_load;
  logic [c_LEN_W-1:0]   w_len;
  logic [c_FRAME_W-1:0] w_tx;
  logic                 w_frame_done;
  logic [7:0]           w_rx_byte;
  logic                 w_legal;
  logic                 w_gap_last;
  logic                 w_wip;
  logic [23:0]          w_poll_next;
  logic                 w_poll_exhausted;

  assign w_legal          = (cmd != c_CMD_ILLEGAL);
  assign w_gap_last       = (r_gap_cnt == c_GAP_W'(CS_GAP - 1));
  assign w_wip            = ((w_rx_byte & c_STATUS_WIP) != 8'h00);
  assign w_poll_next      = r_poll_cnt + 24'd1;
  assign w_poll_exhausted = (w_poll_next >= POLL_LIMIT);

  spi_shift_engine u_shift (
    .clk        (clk),
    .reset      (reset),
    .load       (w_load),
    .length     (w_len),
    .tx_data    (w_tx),
    .miso       (miso),
    .cs_n       (cs_n),
    .sclk       (sclk),
    .mosi       (mosi),
    .frame_done (w_frame_done),
    .rx_byte    (w_rx_byte)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next_state = w_legal ? S_WREN : S_REJECT;
      S_REJECT: w_next_state = S_FINISH;
      S_WREN:   if (w_frame_done) w_next_state = S_GAP;
      S_GAP:    if (w_gap_last) w_next_state = r_oper_pending ? S_OPER : S_POLL;
      S_OPER:   if (w_frame_done) w_next_state = S_GAP;
      S_POLL: begin
        if (w_frame_done) begin
          w_next_state = (!w_wip || w_poll_exhausted) ? S_FINISH : S_GAP;
        end
      end
      S_FINISH: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Frames are loaded on the edge that leaves IDLE or GAP so cs_n falls with the state change
  always_comb begin
    w_load     = 1'b0;
    w_len      = c_LEN_OPCODE;
    w_tx       = {c_OP_WREN, 56'h0};
    busy       = 1'b0;
    bus_active = 1'b0;
    done       = 1'b0;
    error      = r_error;
    case (r_state)
      S_IDLE: begin
        if (start && w_legal) begin
          w_load = 1'b1;
        end
      end
      S_GAP: begin
        if (w_gap_last) begin
          w_load = 1'b1;
          if (r_oper_pending) begin
            w_len = oper_len(r_cmd);
            w_tx  = oper_frame(r_cmd, r_address, r_wdata);
          end else begin
            w_len = c_LEN_POLL;
            w_tx  = {c_OP_RDSR, 56'h0};
          end
        end
      end
      S_FINISH: done = 1'b1;
      default: ;
    endcase
    if (r_state != S_IDLE && r_state != S_FINISH) begin
      busy       = 1'b1;
      bus_active = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmd          <= c_CMD_PROGRAM;
      r_address      <= '0;
      r_wdata        <= '0;
      r_error        <= 1'b0;
      r_oper_pending <= 1'b0;
      r_poll_cnt     <= '0;
      r_gap_cnt      <= '0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_error    <= 1'b0;
        r_poll_cnt <= '0;
        if (w_legal) begin
          r_cmd          <= cmd;
          r_address      <= address;
          r_wdata        <= wdata;
          r_oper_pending <= 1'b1;
        end
      end
      if (r_state == S_REJECT) begin
        r_error <= 1'b1;
      end
      if (r_state == S_POLL && w_frame_done) begin
        r_poll_cnt <= w_poll_next;
        if (w_wip && w_poll_exhausted) begin
          r_error <= 1'b1;
        end
      end
      if (r_state == S_GAP && w_gap_last) begin
        r_oper_pending <= 1'b0;
      end
      r_gap_cnt <= (r_state == S_GAP && !w_gap_last) ? r_gap_cnt + c_GAP_W'(1) : '0;
    end
  end

  assign wp_n   = 1'b1;
  assign hold_n = 1'b1;

endmodule

`default_nettype wire

// File: tb/tb_spi_flash_writer.sv
// ----------------------------------------------------------------------------
// tb_spi_flash_writer : directed + random program/erase sequences against a
//                       behavioural flash model and frame-level reference.
// Revision            : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_spi_flash_writer;

  localparam int          c_GAP   = 4;
  localparam logic [23:0] c_LIMIT = 24'd5;

  logic        clk     = 1'b0;
  logic        reset   = 1'b1;
  logic        start   = 1'b0;
  logic [1:0]  cmd     = 2'd0;
  logic [23:0] address = 24'h0;
  logic [31:0] wdata   = 32'h0;
  logic        miso    = 1'b0;
  logic        busy, done, error, bus_active, cs_n, sclk, mosi, wp_n, hold_n;

  spi_flash_writer #(.CS_GAP(c_GAP), .POLL_LIMIT(c_LIMIT)) dut (
    .clk(clk), .reset(reset), .start(start), .cmd(cmd), .address(address),
    .wdata(wdata), .busy(busy), .done(done), .error(error),
    .bus_active(bus_active), .cs_n(cs_n), .sclk(sclk), .mosi(mosi),
    .miso(miso), .wp_n(wp_n), .hold_n(hold_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [63:0] bits;
    int          n;
    int          t_start;
    int          t_end;
  } frame_t;

  frame_t      frames_q[$];
  frame_t      cur;
  bit          in_frame   = 1'b0;
  bit          poll_frame = 1'b0;
  int          model_busy = 0;
  logic [7:0]  status     = 8'h00;
  int          pin_viol   = 0;

  // Flash model: captures mosi in phase B, drives status bits from phase A onward
  always @(negedge clk) begin
    if (wp_n !== 1'b1 || hold_n !== 1'b1) pin_viol++;
    if (cs_n !== 1'b0) begin
      if (mosi !== 1'b0 || sclk !== 1'b0) pin_viol++;
      if (in_frame) begin
        cur.t_end = cyc;
        if (cur.n > 0) cur.bits = cur.bits << (64 - cur.n);
        frames_q.push_back(cur);
        if (poll_frame && cur.n == 16 && model_busy > 0) model_busy--;
        in_frame = 1'b0;
      end
      miso = 1'b0;
    end else begin
      if (!in_frame) begin
        in_frame   = 1'b1;
        cur.t_start = cyc;
        cur.n       = 0;
        cur.bits    = '0;
        poll_frame  = 1'b0;
      end
      if (sclk === 1'b0) begin
        if (cur.n == 8) begin
          poll_frame = (cur.bits[7:0] == 8'h05);
          status     = {7'($urandom), (model_busy > 0) ? 1'b1 : 1'b0};
        end
        miso = (poll_frame && cur.n >= 8 && cur.n < 16) ? status[15 - cur.n] : 1'b0;
      end else begin
        cur.bits = {cur.bits[62:0], mosi};
        cur.n++;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation and compare the bus traffic and handshake against the reference
  task automatic run_op(input logic [1:0] op, input logic [23:0] addr, input logic [31:0] data,
                        input int busy_polls, input bit inject);
    frame_t      exp_q[$];
    frame_t      f;
    logic [23:0] baddr;
    int          polls, exp_lat, t0, t_done, n_after;
    bit          exp_err, seen;

    baddr = 24'(32'(addr) * 32'd4);
    if (op != 2'd3) begin
      f.bits = {8'h06, 56'h0}; f.n = 8; exp_q.push_back(f);
      case (op)
        2'd0:    begin f.bits = {8'h02, baddr, data};  f.n = 64; end
        2'd1:    begin f.bits = {8'h20, baddr, 32'h0}; f.n = 32; end
        default: begin f.bits = {8'hC7, 56'h0};        f.n = 8;  end
      endcase
      exp_q.push_back(f);
      exp_err = (busy_polls >= int'(c_LIMIT));
      polls   = exp_err ? int'(c_LIMIT) : busy_polls + 1;
      for (int i = 0; i < polls; i++) begin
        f.bits = {8'h05, 56'h0}; f.n = 16; exp_q.push_back(f);
      end
      exp_lat = 1 + (exp_q.size() - 1) * c_GAP;
      foreach (exp_q[i]) exp_lat += 2 * exp_q[i].n;
    end else begin
      exp_err = 1'b1;
      exp_lat = 2;
    end

    frames_q.delete();
    model_busy = busy_polls;
    @(negedge clk);
    start = 1'b1; cmd = op; address = addr; wdata = data; t0 = cyc;
    @(negedge clk);
    start = 1'b0; cmd = 2'($urandom); address = 24'($urandom); wdata = $urandom;
    check("busy_rise", 64'(busy), 64'(1));
    check("bus_active_rise", 64'(bus_active), 64'(1));

    seen = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (inject && cyc == t0 + 30) begin
        start = 1'b1; cmd = 2'($urandom); address = 24'($urandom); wdata = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("done_seen", 64'(seen), 64'(1));
    t_done = cyc;
    check("done_latency", 64'(t_done - t0), 64'(exp_lat));
    check("error_at_done", 64'(error), 64'(exp_err));
    check("busy_at_done", 64'({busy, bus_active}), 64'(0));
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'(0));
    check("error_held", 64'(error), 64'(exp_err));

    check("frame_count", 64'(frames_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < frames_q.size(); i++) begin
      check($sformatf("frame%0d_bits", i), frames_q[i].bits, exp_q[i].bits);
      check($sformatf("frame%0d_len", i), 64'(frames_q[i].n), 64'(exp_q[i].n));
      check($sformatf("frame%0d_cs_low", i), 64'(frames_q[i].t_end - frames_q[i].t_start),
            64'(2 * exp_q[i].n));
      if (i > 0)
        check($sformatf("frame%0d_gap", i), 64'(frames_q[i].t_start - frames_q[i-1].t_end),
              64'(c_GAP));
    end

    n_after = frames_q.size();
    repeat (6) @(negedge clk);
    check("quiet_after_done", 64'({cs_n, 32'(frames_q.size())}), 64'({1'b1, 32'(n_after)}));
  endtask

  initial begin
    int t0;
    bit any_done;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_outputs", 64'({cs_n, sclk, mosi, wp_n, hold_n, busy, done, error, bus_active}),
          64'(9'b1_0_0_1_1_0_0_0_0));
    reset = 1'b0;
    @(negedge clk);

    run_op(2'd0, 24'h000010, 32'hDEADBEEF, 0, 1'b0);
    run_op(2'd1, 24'h000400, $urandom, 3, 1'b0);
    run_op(2'd2, 24'($urandom), $urandom, 1000, 1'b0);
    run_op(2'd3, 24'($urandom), $urandom, 0, 1'b0);
    run_op(2'd0, 24'hFFFFFF, 32'h0123_4567, 1, 1'b1);

    // Reset in the middle of the program frame
    frames_q.delete();
    model_busy = 0;
    @(negedge clk);
    start = 1'b1; cmd = 2'd0; address = 24'($urandom); wdata = $urandom; t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < t0 + 40) @(negedge clk);
    check("pre_rst_cs_low", 64'(cs_n), 64'(0));
    reset = 1'b1;
    @(negedge clk);
    check("midrst_outputs", 64'({cs_n, sclk, mosi, busy, bus_active, done, error}),
          64'(7'b1_0_0_0_0_0_0));
    reset = 1'b0;
    any_done = 1'b0;
    repeat (20) begin
      if (done === 1'b1) any_done = 1'b1;
      @(negedge clk);
    end
    check("midrst_no_done", 64'(any_done), 64'(0));
    run_op(2'd0, 24'($urandom), $urandom, 2, 1'b0);

    for (int i = 0; i < 8; i++) begin
      int bp;
      bp = ($urandom_range(0, 5) == 0) ? 7 : int'($urandom_range(0, 3));
      run_op(2'($urandom_range(0, 3)), 24'($urandom), $urandom, bp, 1'($urandom_range(0, 1)));
    end

    check("pin_rules", 64'(pin_viol), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_flash_writer.md
# spi_flash_writer

Single-bit SPI (mode 0) master that programs and erases the on-board SPI NOR flash. It does a Write Enable, then the requested program or erase command, then polls the status register until the write-in-progress bit clears. It sits beside the quad-mode flash instruction reader. A system arbiter switches the flash pins to this block whenever `bus_active` is high. It gives the CPU/bootloader a way to update flash contents in-system, using the same 32-bit word addressing as the reader.

## Interface
Parameters:
- `CS_GAP`, default 4: clk cycles `cs_n` is held high between consecutive commands (minimum 2).
- `POLL_LIMIT`, default 24'd4_000_000: maximum status-register reads before a timeout error is reported.

Ports:
- `clk` input 1: system clock; SPI clock is clk/2.
- `reset` input 1: synchronous, active-high.
- `start` input 1: single-cycle request; accepted only while `busy`=0.
- `cmd` input 2: operation code.
  - 0 = program one word.
  - 1 = sector erase (4 KiB).
  - 2 = chip erase.
  - 3 = illegal.
- `address` input 24: word address; the byte address is `address`<<2, and bits [23:22] are dropped.
- `wdata` input 32: word to program; sent as byte `wdata[31:24]` first, MSB first.
- `busy` output 1: operation in progress.
- `done` output 1: one-cycle pulse at completion.
- `error` output 1: valid with `done`; held until the next accepted `start`.
- `bus_active` output 1: the block owns the flash pins.
- `cs_n` output 1: flash chip select.
- `sclk` output 1: SPI clock, idles low.
- `mosi` output 1: serial data to flash (IO0/d).
- `miso` input 1: serial data from flash (IO1/q).
- `wp_n` output 1: write protect.
- `hold_n` output 1: hold.

## Operation
- Opcodes:
  - WREN 0x06.
  - Page Program 0x02.
  - Sector Erase 0x20.
  - Chip Erase 0xC7.
  - Read Status 0x05; WIP is bit 0.
- State machine: IDLE → WREN → GAP → OPER → GAP → POLL → (WIP=1: GAP → POLL) / (WIP=0: FINISH) → IDLE.
- IDLE: `start` with `cmd`≠3 latches `cmd`, `address` and `wdata`, then moves to WREN. `start` with `cmd`=3 causes no bus activity, moves to FINISH and reports `error`=1.
- WREN: 8 bits out.
- OPER frame lengths:
  - Program: 64 bits (opcode, 24-bit byte address, 32 data bits).
  - Sector erase: 32 bits.
  - Chip erase: 8 bits.
- POLL: 8 opcode bits out, then 8 status bits in, MSB first. The poll counter increments once per completed POLL.
- When the poll counter reaches `POLL_LIMIT` with WIP still 1, go to FINISH with `error`=1. The counter clears on `start`.
- `start` while `busy`=1 is ignored and its inputs are not latched.
- `wp_n`=1 and `hold_n`=1 at all times.
- `mosi`=0 whenever `cs_n`=1.

## Timing
- Reset value of every output: `cs_n`=1, `sclk`=0, `mosi`=0, `wp_n`=1, `hold_n`=1, `busy`=0, `done`=0, `error`=0, `bus_active`=0.
- `busy` and `bus_active` rise in the cycle after `start` is accepted.
- Bit cell is 2 clk cycles:
  - Phase A: `sclk`=0, `mosi` updated.
  - Phase B: `sclk`=1; `miso` is sampled on the clk edge ending phase B.
- `cs_n` falls together with the first phase A of a frame. It rises on the edge after the last phase B, so `cs_n` is low for exactly 2×(frame bits) cycles.
- GAP lasts `CS_GAP` cycles with `cs_n`=1 and `sclk`=0.
- Program, best case (first poll shows WIP=0): 1 + 16 + `CS_GAP` + 128 + `CS_GAP` + 32 cycles from `start` to FINISH.
- FINISH lasts 1 cycle:
  - `done`=1 and `error` updated.
  - `busy` and `bus_active` fall in the same cycle.
  - A new `start` is accepted on the following cycle.
- Reset mid-operation: all outputs return to their reset values on the next edge, `cs_n` deasserts and no `done` is produced. A partially shifted command is discarded by the flash.

## Structure
- Package `spi_flash_pkg`:
  - Opcode constants.
  - `cmd` encoding constants.
  - State enum typedef.
  - Frame-length constants.
  - Also used by the instruction reader for shared opcodes.
- Sub-module `spi_shift_engine`:
  - Loads up to 64 bits plus a length and shifts MSB first.
  - Generates `sclk`/`cs_n`, captures 8 received bits, and pulses `frame_done`.
  - The top-level FSM sequences frames and gaps.

## Test plan
- Program `address`=0x000010, `wdata`=0xDEADBEEF, flash model WIP=0 on the first poll.
  - MOSI frames in order: 0x06; then 0x02 0x00 0x00 0x40 0xDE 0xAD 0xBE 0xEF; then 0x05.
  - `done`=1 with `error`=0 at cycle 1+16+4+128+4+32 after `start`.
- Sector erase `address`=0x000400, model WIP=1 for 3 polls.
  - Frame 0x20 0x00 0x10 0x00.
  - Exactly 4 POLL frames separated by 4-cycle gaps; `error`=0.
- Chip erase with `POLL_LIMIT`=5 and WIP stuck at 1.
  - Exactly 5 polls, then `done`=1 with `error`=1; `cs_n` stays high afterwards.
- `cmd`=3: `cs_n` never falls; `done`=1, `error`=1 two cycles after `start`.
  - A second `start` issued mid-program is ignored and the latched `wdata` is unchanged.
- Reset asserted 40 cycles into a program.
  - Next cycle: `cs_n`=1, `sclk`=0, `busy`=0, `bus_active`=0, no `done`.
  - A following program completes normally.
